// File: rtl/hamming_acc_unit.sv
// rtl/hamming_acc_unit.sv - multi-cycle per-lane Hamming distance / accumulate / window-average unit
//
// Purpose: computes per-lane popcounts of (dataa ^ datab), sums them into D,
// and depending on opcode n clears state (0), accumulates D with saturation
// and pushes it into a sliding window (1), returns the window average (2), or
// returns the packed per-lane distances (3).
//
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous active-low reset
//   clk_en  - clock qualifier; FSM and all registers hold while low
//   start   - instruction issue, accepted only in IDLE with clk_en high
//   dataa   - census word A (DATA_W)
//   datab   - census word B (DATA_W)
//   n       - opcode (2 bits)
//   result  - instruction result (DATA_W), held until the next op's update
//   done    - high for one qualified cycle when result is valid
//
// Build option: define HAMMING_WINDOW_EN to build the sliding window used by
// AVG; without it AVG returns 0 and ACC only updates the accumulator.

module hamming_acc_unit #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int ACC_W  = 16,
  parameter int WIN    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  input  logic [DATA_W-1:0] dataa,
  input  logic [DATA_W-1:0] datab,
  input  logic [1:0]        n,
  output logic [DATA_W-1:0] result,
  output logic              done
);

  localparam int LW    = DATA_W / LANES;
  localparam int PW    = $clog2(LW + 1);      // per-lane popcount width
  localparam int DW    = $clog2(DATA_W + 1);  // total distance width
  localparam int EXT_W = ((ACC_W > DW) ? ACC_W : DW) + 1;

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_ACC   = 2'd1;
  localparam logic [1:0] OP_AVG   = 2'd2;

  // Illegal parameter combinations stop elaboration.
  if ((DATA_W % LANES) != 0 || LW < 2 || ACC_W > DATA_W ||
      WIN < 2 || WIN > 64 || (WIN & (WIN - 1)) != 0) begin : g_bad_cfg
    $error("hamming_acc_unit: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, S1, S2, DONE} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0]           a_q, b_q, x_q;
  logic [1:0]                  op_q;
  logic [LANES-1:0][PW-1:0]    pop_c, pop_q;
  logic [DW-1:0]               d_total;
  logic [ACC_W-1:0]            acc_q, acc_nx;
  logic [EXT_W-1:0]            acc_ext;
  logic [DATA_W-1:0]           lanes_word, avg_word;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      state <= IDLE;
    else if (clk_en) state <= state_nx;
  end

  // FSM next state; start outside IDLE is simply not looked at
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = S1;
      S1:      state_nx = S2;
      S2:      state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign done = (state == DONE);
  assign x_q  = a_q ^ b_q;

  // Per-lane popcounts of the captured operands
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < LANES; i++)
      for (int j = 0; j < LW; j++)
        pop_c[i] = pop_c[i] + PW'(x_q[i*LW + j]);
  end

  // Lane sum and packed lane word from the registered popcounts
  always_comb begin
    d_total    = '0;
    lanes_word = '0;
    for (int i = 0; i < LANES; i++) begin
      d_total                = d_total + DW'(pop_q[i]);
      lanes_word[i*LW +: LW] = LW'(pop_q[i]);
    end
  end

  // Saturating accumulate, computed one bit wider than either operand
  always_comb begin
    acc_ext = EXT_W'(acc_q) + EXT_W'(d_total);
    if (acc_ext > EXT_W'({ACC_W{1'b1}})) acc_nx = {ACC_W{1'b1}};
    else                                 acc_nx = acc_ext[ACC_W-1:0];
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      pop_q  <= '0;
      acc_q  <= '0;
      result <= '0;
    end else if (clk_en) begin
      if (state == IDLE && start) begin
        a_q  <= dataa;
        b_q  <= datab;
        op_q <= n;
      end
      if (state == S1) pop_q <= pop_c;
      if (state == S2) begin
        case (op_q)
          OP_CLEAR: begin
            acc_q  <= '0;
            result <= '0;
          end
          OP_ACC: begin
            acc_q  <= acc_nx;
            result <= DATA_W'(acc_nx);
          end
          OP_AVG:  result <= avg_word;
          default: result <= lanes_word;
        endcase
      end
    end
  end

`ifdef HAMMING_WINDOW_EN
  localparam int LOG_WIN = $clog2(WIN);
  localparam int SUM_W   = ACC_W + LOG_WIN;

  // Ring buffer of recent distances; wptr_q always points at the oldest entry.
  logic [DW-1:0]      win_q [WIN];
  logic [LOG_WIN-1:0] wptr_q;
  logic [SUM_W-1:0]   wsum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIN; i++) win_q[i] <= '0;
      wptr_q <= '0;
      wsum_q <= '0;
    end else if (clk_en && state == S2) begin
      if (op_q == OP_CLEAR) begin
        for (int i = 0; i < WIN; i++) win_q[i] <= '0;
        wptr_q <= '0;
        wsum_q <= '0;
      end else if (op_q == OP_ACC) begin
        win_q[wptr_q] <= d_total;
        wptr_q        <= wptr_q + LOG_WIN'(1);
        wsum_q        <= wsum_q + SUM_W'(d_total) - SUM_W'(win_q[wptr_q]);
      end
    end
  end

  assign avg_word = DATA_W'(wsum_q >> LOG_WIN);
`else
  assign avg_word = '0;
`endif

endmodule

// File: tb/tb_hamming_acc_unit.sv
// tb/tb_hamming_acc_unit.sv - self-checking bench for hamming_acc_unit

module tb_hamming_acc_unit;

  logic        clk = 1'b0;
  logic        reset, clk_en, start;
  logic [31:0] dataa, datab;
  logic [1:0]  n;
  logic [31:0] result, result8;
  logic        done, done8;

  int total = 0;
  int bad   = 0;

`ifdef HAMMING_WINDOW_EN
  localparam bit WIN_ON = 1'b1;
`else
  localparam bit WIN_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  hamming_acc_unit dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .n(n), .result(result), .done(done)
  );

  hamming_acc_unit #(.ACC_W(8)) dut8 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .n(n), .result(result8), .done(done8)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integers and a queue holding the last 4 distances.
  int unsigned m_acc, m_acc8;
  int unsigned m_win[$];

  function automatic int unsigned lane_dist(logic [31:0] a, logic [31:0] b, int lane);
    logic [31:0] x;
    int unsigned c;
    c = 0;
    x = (a ^ b) >> (8 * lane);
    for (int k = 0; k < 8; k++) c += x[k];
    return c;
  endfunction

  function automatic void m_clear();
    m_acc  = 0;
    m_acc8 = 0;
    m_win.delete();
    repeat (4) m_win.push_back(0);
  endfunction

  function automatic void m_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] e, output logic [31:0] e8);
    int unsigned d, s, junk;
    d = 0;
    for (int l = 0; l < 4; l++) d += lane_dist(a, b, l);
    e  = 0;
    e8 = 0;
    case (op)
      2'd0: m_clear();
      2'd1: begin
        m_acc  = (m_acc + d > 65535) ? 65535 : m_acc + d;
        m_acc8 = (m_acc8 + d > 255) ? 255 : m_acc8 + d;
        if (WIN_ON) begin
          m_win.push_back(d);
          junk = m_win.pop_front();
        end
        e  = m_acc;
        e8 = m_acc8;
      end
      2'd2: begin
        s = 0;
        foreach (m_win[k]) s += m_win[k];
        e  = WIN_ON ? s / 4 : 0;
        e8 = e;
      end
      default: begin
        e  = {8'(lane_dist(a, b, 3)), 8'(lane_dist(a, b, 2)),
              8'(lane_dist(a, b, 1)), 8'(lane_dist(a, b, 0))};
        e8 = e;
      end
    endcase
  endfunction

  // Issue one op with clk_en held high; ok reports exact done timing and result hold.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [31:0] r8, output logic ok);
    @(negedge clk);
    n = op; dataa = a; datab = b; clk_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ok = !done;
    @(posedge clk); #1;
    ok &= !done;
    @(posedge clk); #1;
    ok &= done && done8;
    r  = result;
    r8 = result8;
    @(posedge clk); #1;
    ok &= !done && (result === r);
  endtask

  task automatic run_check(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
    logic [31:0] e, e8, r, r8;
    logic ok;
    m_op(op, a, b, e, e8);
    issue(op, a, b, r, r8, ok);
    check({tag, "_res"}, r, e);
    check({tag, "_res8"}, r8, e8);
    check({tag, "_lat"}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, exp, exp8;
  } vec_t;

  vec_t vt[$];

  function automatic void add(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] e, logic [31:0] e8);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = e; v.exp8 = e8;
    vt.push_back(v);
  endfunction

  initial begin
    logic [31:0] r, r8, a, b;
    logic        ok, prev, saw;
    int          q, rises, first_q, hi_cnt, k;
    logic [1:0]  op;

    reset = 1'b0; clk_en = 1'b0; start = 1'b0; n = 2'd0; dataa = '0; datab = '0;
    m_clear();

    // Directed table
    add(2'd3, 32'hf0800000, 32'h0a000070, 32'h06010003, 32'h06010003);
    add(2'd3, 32'h12345678, 32'h12345678, 32'h0, 32'h0);
    add(2'd3, 32'hffffffff, 32'h0, 32'h08080808, 32'h08080808);
    add(2'd0, 32'h0, 32'h0, 32'd0, 32'd0);
    add(2'd1, 32'hf0800000, 32'h0a000070, 32'd10, 32'd10);
    add(2'd1, 32'he1000000, 32'h85000000, 32'd13, 32'd13);
    add(2'd1, 32'hc2800000, 32'h19800000, 32'd19, 32'd19);
    add(2'd2, 32'h0, 32'h0, WIN_ON ? 32'd4 : 32'd0, WIN_ON ? 32'd4 : 32'd0);
    for (int i = 1; i <= 5; i++)
      add(2'd1, 32'hffffffff, 32'h0, 32'(19 + 32 * i), 32'(19 + 32 * i));
    add(2'd2, 32'h0, 32'h0, WIN_ON ? 32'd32 : 32'd0, WIN_ON ? 32'd32 : 32'd0);
    add(2'd0, 32'h0, 32'h0, 32'd0, 32'd0);
    for (int i = 1; i <= 9; i++)
      add(2'd1, 32'hffffffff, 32'h0, 32'(32 * i), (32 * i > 255) ? 32'd255 : 32'(32 * i));
    add(2'd2, 32'h0, 32'h0, WIN_ON ? 32'd32 : 32'd0, WIN_ON ? 32'd32 : 32'd0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result, 32'd0);
    check("rst_result8", result8, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_done", 32'(done | done8), 32'd0);

    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].a, vt[i].b, r, r8, ok);
      check($sformatf("vec%0d_res", i), r, vt[i].exp);
      check($sformatf("vec%0d_res8", i), r8, vt[i].exp8);
      check($sformatf("vec%0d_lat", i), 32'(ok), 32'd1);
    end

    // clk_en toggling with start held through S1/S2
    @(negedge clk);
    n = 2'd3; dataa = 32'hf0800000; datab = 32'h0a000070; clk_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    q = 0; rises = 0; first_q = -1; hi_cnt = 0; prev = done; r = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      clk_en = (i % 2 == 1);
      start  = (i < 4);
      @(posedge clk); #1;
      if (clk_en) q++;
      if (done && !prev) begin
        rises++;
        if (first_q < 0) first_q = q;
      end
      if (done) begin
        hi_cnt++;
        r = result;
      end
      prev = done;
    end
    check("en_latency", 32'(first_q), 32'd2);
    check("en_done_count", 32'(rises), 32'd1);
    check("en_done_hold", 32'(hi_cnt), 32'd2);
    check("en_result", r, 32'h06010003);
    @(negedge clk);
    clk_en = 1'b1; start = 1'b0;

    // Reset asserted while the op is in S2
    @(negedge clk);
    n = 2'd1; dataa = 32'hffffffff; datab = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done || done8) saw = 1'b1;
    end
    check("s2rst_no_done", 32'(saw), 32'd0);
    check("s2rst_result", result, 32'd0);
    check("s2rst_result8", result8, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    m_clear();
    run_check(2'd3, 32'hf0800000, 32'h0a000070, "s2rst_lanes");
    run_check(2'd1, 32'hf0800000, 32'h0a000070, "s2rst_acc");
    run_check(2'd2, 32'h0, 32'h0, "s2rst_avg");

    // Randomized ops against the model
    run_check(2'd0, 32'h0, 32'h0, "rnd_clear");
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      op = (k == 0) ? 2'd0 : (k <= 5) ? 2'd1 : (k <= 7) ? 2'd2 : 2'd3;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = a;
        2:       b = ~a;
        default: b = a ^ ($urandom & $urandom & $urandom);
      endcase
      run_check(op, a, b, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
